// File: rtl/vx_pending_instr_tracker_pkg.sv
// Shared defaults and helpers for the pending-instruction tracker.
// Commit port numbering is common to the tracker and its users.
package vx_pending_instr_tracker_pkg;

  localparam int DEF_NUM_WARPS   = 8;
  localparam int DEF_NUM_COMMITS = 4;
  localparam int DEF_MAX_PENDING = 63;

  typedef enum logic [1:0] {
    PORT_ALU = 2'd0,
    PORT_LSU = 2'd1,
    PORT_FPU = 2'd2,
    PORT_SFU = 2'd3
  } commit_port_e;

  // A single-warp build still needs a one-bit warp id.
  function automatic int nw_width(input int num_warps);
    return (num_warps > 1) ? $clog2(num_warps) : 1;
  endfunction

endpackage

// File: rtl/vx_pending_instr_tracker_counter.sv
// One warp's in-flight counter: adds the dispatch strobe, subtracts every
// eop commit aimed at this warp, and flags the "exactly one left" state.
module vx_pending_instr_tracker_counter #(
  parameter int CTR_WIDTH   = 6,
  parameter int NUM_COMMITS = 4
) (
  input  logic                   clk,
  input  logic                   i_reset,
  input  logic                   i_incr,
  input  logic [NUM_COMMITS-1:0] i_decr_mask,
  output logic [CTR_WIDTH-1:0]   o_count,
  output logic                   o_alm_empty_r,
  output logic                   o_is_zero
);

  localparam int CW1 = CTR_WIDTH + 1;

  logic [CTR_WIDTH-1:0] r_count;
  logic                 r_alm_empty;
  logic [CW1-1:0]       w_sum;
  logic [CW1-1:0]       w_decr;
  logic [CW1-1:0]       w_count_n;

  always_comb begin
    w_decr = '0;
    for (int p = 0; p < NUM_COMMITS; p++) begin
      w_decr = w_decr + CW1'(i_decr_mask[p]);
    end
  end

  assign w_sum     = {1'b0, r_count} + CW1'(i_incr);
  assign w_count_n = (w_decr > w_sum) ? '0 : (w_sum - w_decr);
  // Next-state zero so the top can register all_empty without extra lag.
  assign o_is_zero = (w_count_n == '0);

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_count     <= '0;
      r_alm_empty <= 1'b0;
    end else begin
      r_count     <= w_count_n[CTR_WIDTH] ? '1 : w_count_n[CTR_WIDTH-1:0];
      r_alm_empty <= (w_count_n == CW1'(1));
`ifndef SYNTHESIS
      assert (w_decr <= w_sum)
        else $error("pending counter underflow: count=%0d incr=%0b decr=%0d", r_count, i_incr, w_decr);
`endif
    end
  end

  assign o_count       = r_count;
  assign o_alm_empty_r = r_alm_empty;

endmodule

// File: rtl/vx_pending_instr_tracker.sv
// Scheduler-side in-flight tracker: per-warp pending counters, serialising
// lock bits, the CSR "almost empty" answer and a global drain flag.
module vx_pending_instr_tracker
  import vx_pending_instr_tracker_pkg::*;
#(
  parameter int NUM_WARPS   = DEF_NUM_WARPS,
  parameter int NUM_COMMITS = DEF_NUM_COMMITS,
  parameter int MAX_PENDING = DEF_MAX_PENDING,
  localparam int NW_WIDTH   = nw_width(NUM_WARPS),
  localparam int CTR_WIDTH  = $clog2(MAX_PENDING + 1)
) (
  input  logic                            clk,
  input  logic                            i_reset,
  input  logic                            i_issue_valid,
  input  logic [NW_WIDTH-1:0]             i_issue_wid,
  input  logic                            i_issue_lock,
  output logic                            o_issue_ready,
  input  logic [NUM_COMMITS-1:0]          i_commit_fire,
  input  logic [NUM_COMMITS-1:0]          i_commit_eop,
  input  logic [NUM_COMMITS*NW_WIDTH-1:0] i_commit_wid,
  input  logic [NW_WIDTH-1:0]             i_alm_empty_wid,
  output logic                            o_alm_empty,
  input  logic                            i_unlock_warp,
  input  logic [NW_WIDTH-1:0]             i_unlock_wid,
  output logic [NUM_WARPS-1:0]            o_warp_locked,
  output logic                            o_all_empty
);

  logic [NUM_WARPS-1:0]                  w_incr;
  logic [NUM_WARPS-1:0]                  w_decr_any;
  logic [NUM_WARPS-1:0]                  w_alm_empty_r;
  logic [NUM_WARPS-1:0]                  w_is_zero;
  logic [NUM_WARPS-1:0][NUM_COMMITS-1:0] w_decr_mask;
  logic [CTR_WIDTH-1:0]                  w_count [NUM_WARPS];
  logic                                  w_issue_fire;
  logic [NUM_WARPS-1:0]                  r_warp_locked;
  logic                                  r_all_empty;

  // A commit to a full warp frees a slot in the same cycle it is reused.
  assign o_issue_ready = !((w_count[i_issue_wid] == CTR_WIDTH'(MAX_PENDING)) && !w_decr_any[i_issue_wid]);
  assign w_issue_fire  = i_issue_valid && o_issue_ready;

  genvar gi, gp;
  generate
    for (gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
      assign w_incr[gi] = w_issue_fire && (i_issue_wid == NW_WIDTH'(gi));

      for (gp = 0; gp < NUM_COMMITS; gp++) begin : g_port
        assign w_decr_mask[gi][gp] = i_commit_fire[gp] && i_commit_eop[gp] &&
                                     (i_commit_wid[gp*NW_WIDTH +: NW_WIDTH] == NW_WIDTH'(gi));
      end

      assign w_decr_any[gi] = |w_decr_mask[gi];

      vx_pending_instr_tracker_counter #(
        .CTR_WIDTH   (CTR_WIDTH),
        .NUM_COMMITS (NUM_COMMITS)
      ) u_counter (
        .clk           (clk),
        .i_reset       (i_reset),
        .i_incr        (w_incr[gi]),
        .i_decr_mask   (w_decr_mask[gi]),
        .o_count       (w_count[gi]),
        .o_alm_empty_r (w_alm_empty_r[gi]),
        .o_is_zero     (w_is_zero[gi])
      );
    end
  endgenerate

  // Unlock is applied last so it wins over a same-cycle lock.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_warp_locked <= '0;
    end else begin
      if (w_issue_fire && i_issue_lock) r_warp_locked[i_issue_wid] <= 1'b1;
      if (i_unlock_warp) r_warp_locked[i_unlock_wid] <= 1'b0;
`ifndef SYNTHESIS
      assert (!(w_issue_fire && i_issue_lock && i_unlock_warp && (i_issue_wid == i_unlock_wid)))
        else $error("warp %0d locked and unlocked in the same cycle", i_issue_wid);
      if (i_unlock_warp && !r_warp_locked[i_unlock_wid])
        $warning("unlock of warp %0d which is not locked", i_unlock_wid);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) r_all_empty <= 1'b1;
    else         r_all_empty <= &w_is_zero;
  end

  assign o_alm_empty   = w_alm_empty_r[i_alm_empty_wid];
  assign o_warp_locked = r_warp_locked;
  assign o_all_empty   = r_all_empty;

endmodule

// File: tb/tb_vx_pending_instr_tracker.sv
// Directed bench for the pending-instruction tracker: stimulus queues the
// expected output per cycle, a negedge monitor pops and compares.
module tb_vx_pending_instr_tracker;
  import vx_pending_instr_tracker_pkg::*;

  localparam int NW = 8;
  localparam int NC = 4;
  localparam int WW = 3;

  localparam int K_READY = 0;
  localparam int K_ALM   = 1;
  localparam int K_ALL   = 2;
  localparam int K_LOCK  = 3;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              issue_valid;
  logic [WW-1:0]     issue_wid;
  logic              issue_lock;
  logic              issue_ready;
  logic [NC-1:0]     commit_fire;
  logic [NC-1:0]     commit_eop;
  logic [NC*WW-1:0]  commit_wid;
  logic [WW-1:0]     alm_wid;
  logic              alm_empty;
  logic              unlock;
  logic [WW-1:0]     unlock_wid;
  logic [NW-1:0]     locked;
  logic              all_empty;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vx_pending_instr_tracker #(
    .NUM_WARPS   (NW),
    .NUM_COMMITS (NC),
    .MAX_PENDING (63)
  ) dut (
    .clk             (clk),
    .i_reset         (rst),
    .i_issue_valid   (issue_valid),
    .i_issue_wid     (issue_wid),
    .i_issue_lock    (issue_lock),
    .o_issue_ready   (issue_ready),
    .i_commit_fire   (commit_fire),
    .i_commit_eop    (commit_eop),
    .i_commit_wid    (commit_wid),
    .i_alm_empty_wid (alm_wid),
    .o_alm_empty     (alm_empty),
    .i_unlock_warp   (unlock),
    .i_unlock_wid    (unlock_wid),
    .o_warp_locked   (locked),
    .o_all_empty     (all_empty)
  );

  task automatic expect_at(input int dly, input int kind, input logic [31:0] val, input string name);
    exp_t e;
    e.cyc  = cyc + dly;
    e.kind = kind;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    issue_lock  = 1'b0;
    commit_fire = '0;
    commit_eop  = '0;
    unlock      = 1'b0;
  endtask

  task automatic issue(input int w, input bit lk);
    issue_valid = 1'b1;
    issue_wid   = w[WW-1:0];
    issue_lock  = lk;
  endtask

  task automatic commit(input int p, input int w, input bit eop);
    commit_fire[p]          = 1'b1;
    commit_eop[p]           = eop;
    commit_wid[p*WW +: WW]  = w[WW-1:0];
  endtask

  always @(negedge clk) begin
    logic [31:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        case (sb[i].kind)
          K_READY: act = {31'b0, issue_ready};
          K_ALM:   act = {31'b0, alm_empty};
          K_ALL:   act = {31'b0, all_empty};
          default: act = {24'b0, locked};
        endcase
        n_tests++;
        if (sb[i].cyc < cyc) begin
          n_fail++;
          $display("[TB] FAIL %s: check slot cycle %0d passed unchecked (now %0d)", sb[i].name, sb[i].cyc, cyc);
        end else if (act !== sb[i].val) begin
          n_fail++;
          $display("[TB] FAIL %s: cycle %0d got 0x%0h expected 0x%0h", sb[i].name, cyc, act, sb[i].val);
        end else begin
          $display("[TB] ok   %s: cycle %0d value 0x%0h", sb[i].name, cyc, act);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; issue_valid = 1'b0; issue_wid = '0; issue_lock = 1'b0;
    commit_fire = '0; commit_eop = '0; commit_wid = '0;
    alm_wid = '0; unlock = 1'b0; unlock_wid = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state, then idle query of every warp
    expect_at(0, K_ALL,   1, "rst_all_empty");
    expect_at(0, K_LOCK,  0, "rst_locked");
    expect_at(0, K_READY, 1, "rst_ready");
    for (int w = 0; w < NW; w++) begin
      alm_wid = w[WW-1:0];
      expect_at(0, K_ALM, 0, $sformatf("rst_alm_w%0d", w));
      tick();
    end

    // Warp 2: three dispatches (first locks), two commits, unlock, drain
    alm_wid = 3'd2;
    issue(2, 1);
    expect_at(1, K_LOCK, 32'h04, "w2_lock_set");
    expect_at(1, K_ALM,  1,      "w2_alm_cnt1");
    expect_at(1, K_ALL,  0,      "w2_all_busy");
    tick();
    issue(2, 0); tick();
    issue(2, 0);
    expect_at(1, K_ALM, 0, "w2_alm_cnt3");
    tick();
    commit(int'(PORT_ALU), 2, 1);
    expect_at(1, K_ALM, 0, "w2_alm_cnt2");
    tick();
    commit(int'(PORT_LSU), 2, 1);
    expect_at(0, K_ALM, 0, "w2_alm_before_last");
    expect_at(1, K_ALM, 1, "w2_alm_after_commit");
    tick();
    unlock = 1'b1; unlock_wid = 3'd2;
    expect_at(0, K_LOCK, 32'h04, "w2_lock_held");
    expect_at(1, K_LOCK, 0,      "w2_unlocked");
    tick();
    commit(int'(PORT_FPU), 2, 1);
    expect_at(1, K_ALL, 1, "w2_drain_all_empty");
    expect_at(1, K_ALM, 0, "w2_alm_cnt0");
    tick();

    // Warp 1: issue plus two same-warp commits in one cycle from count 2
    alm_wid = 3'd1;
    issue(1, 0); tick();
    issue(1, 0);
    expect_at(1, K_ALM, 0, "w1_cnt2");
    tick();
    issue(1, 0);
    commit(int'(PORT_ALU), 1, 1);
    commit(int'(PORT_SFU), 1, 1);
    expect_at(0, K_READY, 1, "w1_ready");
    expect_at(1, K_ALM,   1, "w1_net_cnt1");
    expect_at(1, K_ALL,   0, "w1_busy");
    tick();
    commit(int'(PORT_ALU), 1, 1);
    expect_at(1, K_ALL, 1, "w1_drained");
    tick();

    // Warp 5: a fire without eop must not decrement
    alm_wid = 3'd5;
    issue(5, 0); tick();
    commit(int'(PORT_LSU), 5, 0);
    expect_at(1, K_ALM, 1, "w5_no_eop_hold");
    expect_at(1, K_ALL, 0, "w5_no_eop_busy");
    tick();
    commit(int'(PORT_LSU), 5, 1);
    expect_at(1, K_ALL, 1, "w5_eop_drain");
    tick();

    // Warp 0: fill to 63, stall, bypass with same-cycle commit
    alm_wid = 3'd0;
    for (int i = 0; i < 63; i++) begin
      issue(0, 0);
      tick();
    end
    issue(0, 0);
    expect_at(0, K_READY, 0, "w0_full_stall");
    tick();
    issue(0, 0);
    commit(int'(PORT_FPU), 0, 1);
    expect_at(0, K_READY, 1, "w0_full_bypass");
    tick();
    issue(0, 0);
    expect_at(0, K_READY, 0, "w0_still_full");
    expect_at(0, K_ALM,   0, "w0_full_alm");
    tick();
    issue_wid = 3'd3;
    expect_at(0, K_READY, 1, "w3_ready_while_w0_full");
    tick();

    // Clear, build counts {4,1}, then reset mid-operation
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue(0, 1);
      tick();
    end
    issue(1, 0); tick();
    alm_wid = 3'd1;
    expect_at(0, K_ALM,  1,    "pre_rst_w1_alm");
    expect_at(0, K_LOCK, 32'h01, "pre_rst_locked");
    expect_at(0, K_ALL,  0,    "pre_rst_busy");
    rst = 1'b1;
    commit(int'(PORT_ALU), 0, 1);
    expect_at(1, K_ALL,  1, "rst_mid_all_empty");
    expect_at(1, K_LOCK, 0, "rst_mid_lock_clr");
    expect_at(1, K_ALM,  0, "rst_mid_alm_clr");
    tick();
    rst = 1'b0;
    alm_wid = 3'd0;
    issue(0, 0);
    expect_at(1, K_ALM, 1, "post_rst_w0_cnt1");
    tick();
    commit(int'(PORT_SFU), 0, 1);
    expect_at(1, K_ALL, 1, "post_rst_drain");
    tick();

    tick();
    tick();
    foreach (sb[i]) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL %s: never checked, expected 0x%0h at cycle %0d", sb[i].name, sb[i].val, sb[i].cyc);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vx_pending_instr_tracker.md
Name: VX_pending_instr_tracker

Overview:
- Scheduler-side responder for the CSR unit's scheduler handshake.
- Keeps a per-warp count of in-flight instructions: incremented at dispatch, decremented at commit. Answers the CSR unit's "almost empty" query for a given warp.
- Holds a per-warp lock bit: set when a serialising instruction (CSR/SFU) is dispatched, cleared by the CSR unit's unlock strobe.
- Sits in the scheduler, between the issue stage and all commit ports.

Parameters:
- NUM_WARPS, `NUM_WARPS, number of warps tracked.
- NUM_COMMITS, 4, number of independent commit ports (ALU/LSU/FPU/SFU).
- MAX_PENDING, 63, maximum in-flight instructions per warp.
- CTR_WIDTH, `CLOG2(MAX_PENDING+1), counter width (derived; do not override).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- issue_valid  in  1  dispatch of one instruction (already sop-qualified by the issue stage)
- issue_wid  in  `NW_WIDTH  warp of the dispatched instruction
- issue_lock  in  1  dispatched instruction serialises its warp
- issue_ready  out  1  deasserted when issue_wid's counter is at MAX_PENDING
- commit_fire  in  NUM_COMMITS  per-port commit handshake (valid&&ready)
- commit_eop  in  NUM_COMMITS  per-port eop; decrement only when fire&&eop
- commit_wid  in  NUM_COMMITS*`NW_WIDTH  per-port warp id
- alm_empty_wid  in  `NW_WIDTH  warp queried by the CSR unit
- alm_empty  out  1  queried warp has exactly one pending instruction (the querier itself)
- unlock_warp  in  1  unlock strobe from the CSR unit
- unlock_wid  in  `NW_WIDTH  warp to unlock
- warp_locked  out  NUM_WARPS  per-warp lock state
- all_empty  out  1  every counter is zero (used by barrier/ebreak drain)

Behaviour:
- Reset: all counters 0, alm_empty_r all 0, warp_locked all 0, all_empty 1. Reset mid-operation discards all in-flight accounting; no residual decrement is applied afterwards.
- Counter update per warp w, every cycle:
  - incr = issue_valid && issue_ready && issue_wid==w
  - decr = popcount over ports p of (commit_fire[p] && commit_eop[p] && commit_wid[p]==w), range 0..NUM_COMMITS
  - count_n = count + incr - decr, computed at CTR_WIDTH+1 bits.
  - Simultaneous incr and decr on the same warp is legal; net change applies.
  - Multiple ports decrementing the same warp in one cycle is legal.
- Underflow (decr > count+incr): simulation assertion; counter saturates at 0.
- issue_ready: combinational; 0 iff count[issue_wid]==MAX_PENDING and no decrement to that warp is happening this cycle. The decrement bypass is required.
- alm_empty:
  - alm_empty_r[w] <= (count_n[w]==1), a registered flag per warp.
  - alm_empty = alm_empty_r[alm_empty_wid], a combinational mux of registered state. Latency from the final commit to alm_empty=1 is one cycle.
  - The CSR instruction is counted at dispatch, so "almost empty" means 1, not 0.
- all_empty: registered; next value = AND over w of (count_n[w]==0).
- Lock:
  - warp_locked[issue_wid] <= 1 when incr && issue_lock.
  - warp_locked[unlock_wid] <= 0 when unlock_warp.
  - Same-warp set and clear in the same cycle: assertion error; clear wins.
  - unlock of a warp that is not locked: no-op plus a simulation warning.
- No internal FSM beyond the counters and lock bits. All outputs except issue_ready and the alm_empty mux are flop outputs.

Decomposition:
- Shared package (VX_gpu_pkg): none new. Reuse `NW_WIDTH and `NUM_WARPS.
- Sub-module VX_pending_counter: one instance per warp, parameterised by CTR_WIDTH and NUM_COMMITS. Inputs incr and decr_mask; outputs count, alm_empty_r and is_zero. Holds the saturate and underflow assertions.
- The top level does wid decode, the popcount feed, the lock bits and the output muxes.

Test Plan:
- Reset then idle → all_empty=1, alm_empty=0 for every wid, warp_locked=0, issue_ready=1.
- Dispatch 3 instrs to wid 2 (one with issue_lock), commit 2 with eop; query wid 2 → alm_empty=1 one cycle after the 2nd commit; warp_locked[2]=1; unlock_warp wid 2 → warp_locked[2]=0 next cycle.
- Same cycle: issue to wid 1 plus commits on ports 0 and 3 to wid 1, from count 2 → count 1, alm_empty_r[1]=1.
- Fill wid 0 to 63 → issue_ready=0; a wid 0 commit in the same cycle as the 64th issue → issue_ready=1 and count stays 63.
- commit_fire=1 with commit_eop=0 on wid 5 → no decrement; count unchanged.
- Reset asserted with counts {4,1,0,...} → next cycle all counters 0, all_empty=1, warp_locked cleared.
